// File: rtl/coax_line_frontend.sv
// Coax line front end: rx synchroniser and glitch filter, tx driver gating with
// post-transmit rx blanking, loopback/disable modes and an rx-core interrupt block.

module coax_line_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) chain <= '0;
      else          chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];
endmodule

module coax_line_filter #(
   parameter int LENGTH = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic s,
   output logic f
);
   localparam logic [3:0] LEN = 4'(LENGTH);

   logic [3:0] cnt;

   // f only moves after LENGTH consecutive samples disagree with it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         f   <= 1'b0;
         cnt <= 4'd0;
      end else if (s == f) begin
         cnt <= 4'd0;
      end else if (cnt + 4'd1 == LEN) begin
         f   <= s;
         cnt <= 4'd0;
      end else begin
         cnt <= cnt + 4'd1;
      end
   end
endmodule

module coax_line_irq (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_active_in,
   input  logic       rx_error_in,
   input  logic [1:0] irq_mask,
   input  logic [1:0] irq_clear,
   output logic [1:0] irq_status,
   output logic       irq
);
   logic [1:0] ev_q;
   logic [1:0] rise;

   assign rise = {rx_error_in, rx_active_in} & ~ev_q;

   // a fresh edge wins over a coincident clear strobe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ev_q       <= 2'b00;
         irq_status <= 2'b00;
         irq        <= 1'b0;
      end else begin
         ev_q       <= {rx_error_in, rx_active_in};
         irq_status <= rise | (irq_status & ~irq_clear);
         irq        <= |(irq_status & ~irq_mask);
      end
   end
endmodule

module coax_line_frontend #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_LENGTH = 3,
   parameter int GUARD_CLOCKS  = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_pin,
   input  logic       tx_in,
   input  logic       tx_active_in,
   input  logic [1:0] mode,
   output logic       line_tx,
   output logic       line_tx_active,
   output logic       rx_out,
   output logic       guard_active,
   input  logic       rx_active_in,
   input  logic       rx_error_in,
   input  logic [1:0] irq_mask,
   input  logic [1:0] irq_clear,
   output logic [1:0] irq_status,
   output logic       irq
);
   localparam logic [7:0] GUARD = 8'(GUARD_CLOCKS);

   logic       s;
   logic       f;
   logic [1:0] mode_q;
   logic       tx_q;
   logic [7:0] guard_cnt;
   logic       normal;
   logic       blank;

   coax_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (rx_pin),
      .q       (s)
   );

   coax_line_filter #(.LENGTH(FILTER_LENGTH)) u_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .s       (s),
      .f       (f)
   );

   coax_line_irq u_irq (
      .clk          (clk),
      .reset_n      (reset_n),
      .rx_active_in (rx_active_in),
      .rx_error_in  (rx_error_in),
      .irq_mask     (irq_mask),
      .irq_clear    (irq_clear),
      .irq_status   (irq_status),
      .irq          (irq)
   );

   assign normal       = (mode_q == 2'b00);
   assign blank        = normal && (tx_active_in || guard_cnt != 8'd0);
   assign guard_active = blank && reset_n;

   // mode is held off while tx_q is set so the guard load that follows a
   // transmit still sees the mode the transmit ran under
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q         <= 2'b00;
         tx_q           <= 1'b0;
         guard_cnt      <= 8'd0;
         line_tx        <= 1'b0;
         line_tx_active <= 1'b0;
         rx_out         <= 1'b0;
      end else begin
         tx_q <= tx_active_in;
         if (!tx_active_in && !tx_q && guard_cnt == 8'd0)
            mode_q <= mode;

         if (tx_active_in)
            guard_cnt <= 8'd0;
         else if (tx_q && normal)
            guard_cnt <= GUARD;
         else if (guard_cnt != 8'd0)
            guard_cnt <= guard_cnt - 8'd1;

         line_tx_active <= tx_active_in && normal;
         line_tx        <= tx_in && tx_active_in && normal;

         case (mode_q)
            2'b00:   rx_out <= blank ? 1'b0 : f;
            2'b01:   rx_out <= tx_in && tx_active_in;
            default: rx_out <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_coax_line_frontend.sv
// Bench for coax_line_frontend: directed scenarios plus a randomized run, all
// checked every cycle against a history-based reference model.

module tb_coax_line_frontend;
   localparam int SYNC = 2;
   localparam int FLEN = 3;
   localparam int GCLK = 32;
   localparam int N    = 8192;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       rx_pin = 1'b0;
   logic       tx_in = 1'b0;
   logic       tx_active_in = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       rx_active_in = 1'b0;
   logic       rx_error_in = 1'b0;
   logic [1:0] irq_mask = 2'b00;
   logic [1:0] irq_clear = 2'b00;
   logic       line_tx, line_tx_active, rx_out, guard_active, irq;
   logic [1:0] irq_status;

   always #5 clk = ~clk;

   coax_line_frontend #(
      .SYNC_STAGES   (SYNC),
      .FILTER_LENGTH (FLEN),
      .GUARD_CLOCKS  (GCLK)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .rx_pin         (rx_pin),
      .tx_in          (tx_in),
      .tx_active_in   (tx_active_in),
      .mode           (mode),
      .line_tx        (line_tx),
      .line_tx_active (line_tx_active),
      .rx_out         (rx_out),
      .guard_active   (guard_active),
      .rx_active_in   (rx_active_in),
      .rx_error_in    (rx_error_in),
      .irq_mask       (irq_mask),
      .irq_clear      (irq_clear),
      .irq_status     (irq_status),
      .irq            (irq)
   );

   int checks = 0;
   int errors = 0;
   int k = 0;

   // input history per clock edge (index 0 = reset state) and model state
   bit       rxh[N], txh[N], txdh[N], rah[N], reh[N], fh[N];
   bit [1:0] modeh[N], maskh[N], clrh[N], mqh[N], sth[N];
   int       gdh[N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // level the filter sees at edge j: rx_pin delayed through the synchroniser
   function automatic bit s_at(input int j);
      return (j - SYNC >= 1) ? rxh[j - SYNC] : 1'b0;
   endfunction

   task automatic step();
      bit flip;
      bit exp_rx;
      @(posedge clk);
      #1;
      k++;
      rxh[k] = rx_pin;   txh[k] = tx_active_in; txdh[k] = tx_in;
      rah[k] = rx_active_in; reh[k] = rx_error_in;
      modeh[k] = mode;   maskh[k] = irq_mask;   clrh[k] = irq_clear;

      flip = 1'b1;
      for (int i = 0; i < FLEN; i++)
         if (s_at(k - i) == fh[k-1]) flip = 1'b0;
      fh[k] = flip ? ~fh[k-1] : fh[k-1];

      mqh[k] = (!txh[k] && !txh[k-1] && gdh[k-1] == 0) ? modeh[k] : mqh[k-1];
      if (mqh[k-1] == 2'b00 && txh[k-1] && !txh[k]) gdh[k] = GCLK;
      else if (txh[k] || gdh[k-1] == 0)             gdh[k] = 0;
      else                                          gdh[k] = gdh[k-1] - 1;

      sth[k] = ({reh[k], rah[k]} & ~{reh[k-1], rah[k-1]}) | (sth[k-1] & ~clrh[k]);

      case (mqh[k-1])
         2'b00:   exp_rx = (txh[k] || gdh[k-1] != 0) ? 1'b0 : fh[k-1];
         2'b01:   exp_rx = txdh[k] & txh[k];
         default: exp_rx = 1'b0;
      endcase

      chk("line_tx_active", 32'(line_tx_active), 32'(txh[k] && mqh[k-1] == 2'b00));
      chk("line_tx", 32'(line_tx), 32'(txdh[k] && txh[k] && mqh[k-1] == 2'b00));
      chk("rx_out", 32'(rx_out), 32'(exp_rx));
      chk("guard_active", 32'(guard_active), 32'(mqh[k] == 2'b00 && (txh[k] || gdh[k] != 0)));
      chk("irq_status", 32'(irq_status), 32'(sth[k]));
      chk("irq", 32'(irq), 32'(|(sth[k-1] & ~maskh[k])));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_line_tx"}, 32'(line_tx), 32'd0);
      chk({tag, "_line_tx_active"}, 32'(line_tx_active), 32'd0);
      chk({tag, "_rx_out"}, 32'(rx_out), 32'd0);
      chk({tag, "_guard"}, 32'(guard_active), 32'd0);
      chk({tag, "_irq_status"}, 32'(irq_status), 32'd0);
      chk({tag, "_irq"}, 32'(irq), 32'd0);
   endtask

   // async assert with an immediate check, synchronous release, model restart
   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk_zero("rst_async");
      rx_pin = 1'b0; tx_in = 1'b0; tx_active_in = 1'b0; mode = 2'b00;
      rx_active_in = 1'b0; rx_error_in = 1'b0; irq_mask = 2'b00; irq_clear = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("rst_held");
      @(negedge clk);
      reset_n = 1'b1;
      k = 0;
   endtask

   initial begin
      int hi;
      int ga;
      int rx_run;
      int tx_run;
      logic [3:0] pat;

      #2;
      do_reset();

      // clean rising edge: SYNC + FLEN + 1 cycles of latency
      rx_pin = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (i == 5) chk("edge_lat_early", 32'(rx_out), 32'd0);
         if (i == 6) chk("edge_lat", 32'(rx_out), 32'd1);
      end
      rx_pin = 1'b0;
      repeat (12) step();

      // 2-cycle glitch vanishes, 3-cycle pulse survives intact
      hi = 0;
      rx_pin = 1'b1;
      repeat (2) begin step(); hi += int'(rx_out); end
      rx_pin = 1'b0;
      repeat (12) begin step(); hi += int'(rx_out); end
      chk("glitch2_hidden", 32'(hi), 32'd0);
      hi = 0;
      rx_pin = 1'b1;
      repeat (3) begin step(); hi += int'(rx_out); end
      rx_pin = 1'b0;
      repeat (12) begin step(); hi += int'(rx_out); end
      chk("pulse3_len", 32'(hi), 32'd3);

      // transmit burst with rx toggling: blanking through tx and guard
      hi = 0; ga = 0;
      tx_active_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         rx_pin = 1'(i / 4); tx_in = 1'($urandom);
         step(); hi += int'(line_tx_active); ga += int'(guard_active);
      end
      tx_active_in = 1'b0;
      for (int i = 0; i < 50; i++) begin
         rx_pin = 1'((i / 5) % 2);
         step(); hi += int'(line_tx_active); ga += int'(guard_active);
      end
      chk("tx_active_len", 32'(hi), 32'd10);
      chk("guard_len", 32'(ga), 32'd42);

      // internal loopback
      mode = 2'b01; rx_pin = 1'b0;
      repeat (3) step();
      pat = 4'b1101;
      tx_active_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tx_in = pat[i];
         step();
         chk("loop_rx", 32'(rx_out), 32'(pat[i]));
         chk("loop_lta", 32'(line_tx_active), 32'd0);
      end
      tx_active_in = 1'b0; tx_in = 1'b0;
      repeat (3) step();

      // mode write during transmit is deferred until the guard expires
      mode = 2'b00;
      repeat (3) step();
      tx_active_in = 1'b1; tx_in = 1'b1;
      repeat (3) step();
      mode = 2'b01;
      repeat (5) begin step(); chk("defer_lta", 32'(line_tx_active), 32'd1); end
      tx_active_in = 1'b0;
      repeat (40) step();
      tx_active_in = 1'b1;
      repeat (3) begin step(); chk("mode01_lta", 32'(line_tx_active), 32'd0); end
      tx_active_in = 1'b0; tx_in = 1'b0; mode = 2'b00;
      repeat (4) step();

      // interrupt masking and set-beats-clear
      irq_mask = 2'b10; rx_error_in = 1'b1;
      step(); step();
      chk("irq_st_err", 32'(irq_status), 32'd2);
      chk("irq_masked", 32'(irq), 32'd0);
      irq_mask = 2'b00;
      step();
      chk("irq_unmasked", 32'(irq), 32'd1);
      rx_error_in = 1'b0;
      step();
      rx_error_in = 1'b1; irq_clear = 2'b10;
      step();
      irq_clear = 2'b00;
      chk("set_beats_clr", 32'(irq_status), 32'd2);
      irq_clear = 2'b10;
      step();
      irq_clear = 2'b00;
      chk("clr_done", 32'(irq_status), 32'd0);
      rx_error_in = 1'b0;
      repeat (3) step();

      // randomized traffic
      rx_run = 0; tx_run = 0;
      for (int i = 0; i < 1500; i++) begin
         if (i % 300 == 0)
            mode = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if (rx_run == 0) begin
            rx_pin = ~rx_pin;
            rx_run = int'($urandom_range(1, 6));
         end
         rx_run--;
         if (tx_run > 0) begin
            tx_run--;
            if (tx_run == 0) tx_active_in = 1'b0;
         end else if ($urandom_range(0, 59) == 0) begin
            tx_active_in = 1'b1;
            tx_run = int'($urandom_range(3, 15));
         end
         tx_in = 1'($urandom);
         if ($urandom_range(0, 7) == 0) rx_active_in = ~rx_active_in;
         if ($urandom_range(0, 7) == 0) rx_error_in = ~rx_error_in;
         irq_clear = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
         if ($urandom_range(0, 49) == 0) irq_mask = 2'($urandom);
         step();
      end
      tx_active_in = 1'b0; irq_clear = 2'b00; mode = 2'b00;
      repeat (40) step();

      // reset in the middle of a transmit: driver drops, no guard afterwards
      tx_active_in = 1'b1; tx_in = 1'b1;
      repeat (5) step();
      @(negedge clk);
      do_reset();
      repeat (10) begin
         step();
         chk("no_guard_after_rst", 32'(guard_active), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
